// File: rtl/mul_share_pkg.sv
// Shared types, defaults and operand helper for the two-port multiplier scheduler.
// Build option MUL_SHARE_ZERO_SKIP_EN is consumed by mul_share_arb.
package mul_share_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RES_W_DEF = 64;

  // Scheduler state encoding
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_BUSY  = 2'd2;
  localparam state_t S_RESP  = 2'd3;

  // Widen an XLEN operand to the multiplier's XLEN+1 input, sign or zero filled.
  function automatic logic [XLEN_DEF:0] sext33(input logic [XLEN_DEF-1:0] x,
                                               input logic                is_signed);
    return {is_signed & x[XLEN_DEF-1], x};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational; zero latency, no backpressure.
// The requester that was not served last wins a tie.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_served,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = last_served ? 2'b01 : 2'b10;
    end else begin
      grant = {valid1, valid0};
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one iterative multiplier between two issue ports: 1 accept cycle + 1 response cycle around it.
// One op in flight; a held response stalls all new grants. Option: MUL_SHARE_ZERO_SKIP_EN.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RES_W = RES_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_x,
  input  logic [XLEN-1:0]  req0_y,
  input  logic             req0_signed,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_x,
  input  logic [XLEN-1:0]  req1_y,
  input  logic             req1_signed,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [RES_W-1:0] resp0_result,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [RES_W-1:0] resp1_result,
  output logic [XLEN:0]    mul_src1,
  output logic [XLEN:0]    mul_src2,
  output logic             mul_in_valid,
  input  logic             mul_in_ready,
  input  logic             mul_out_valid,
  input  logic [RES_W-1:0] mul_result
);

  state_t           state;
  logic             rr_ptr;
  logic             owner;
  logic [XLEN-1:0]  x_q;
  logic [XLEN-1:0]  y_q;
  logic             sgn_q;
  logic [RES_W-1:0] res_q;

  logic [1:0]       grant;
  logic             in_idle;
  logic             accept;
  logic             last_served;
  logic             resp_take;
  logic [XLEN-1:0]  acc_x;
  logic [XLEN-1:0]  acc_y;
  logic             acc_sgn;

  // rr_ptr names the favoured port, so the port served last is its complement.
  assign last_served = ~rr_ptr;

  rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_served (last_served),
    .grant       (grant)
  );

  assign in_idle    = (state == S_IDLE);
  assign req0_ready = in_idle & grant[0];
  assign req1_ready = in_idle & grant[1];
  assign accept     = in_idle & (|grant);

  assign acc_x   = grant[1] ? req1_x      : req0_x;
  assign acc_y   = grant[1] ? req1_y      : req0_y;
  assign acc_sgn = grant[1] ? req1_signed : req0_signed;

  assign mul_in_valid = (state == S_ISSUE);

  generate
    if (XLEN == XLEN_DEF) begin : g_pkg_ext
      assign mul_src1 = sext33(y_q, sgn_q);
      assign mul_src2 = sext33(x_q, sgn_q);
    end else begin : g_param_ext
      assign mul_src1 = {sgn_q & y_q[XLEN-1], y_q};
      assign mul_src2 = {sgn_q & x_q[XLEN-1], x_q};
    end
  endgenerate

  assign resp0_valid  = (state == S_RESP) & ~owner;
  assign resp1_valid  = (state == S_RESP) &  owner;
  assign resp0_result = res_q;
  assign resp1_result = res_q;
  assign resp_take    = owner ? resp1_ready : resp0_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      rr_ptr <= 1'b0;
      owner  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      sgn_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            x_q   <= acc_x;
            y_q   <= acc_y;
            sgn_q <= acc_sgn;
            owner <= grant[1];
`ifdef MUL_SHARE_ZERO_SKIP_EN
            // A zero operand has a known product; bypass the multiplier entirely.
            if ((acc_x == '0) || (acc_y == '0)) begin
              res_q <= '0;
              state <= S_RESP;
            end else begin
              state <= S_ISSUE;
            end
`else
            state <= S_ISSUE;
`endif
          end
        end
        S_ISSUE: begin
          if (mul_in_ready) begin
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mul_out_valid) begin
            res_q <= mul_result;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_take) begin
            rr_ptr <= ~owner;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboarded bench for mul_share_arb with a behavioural iterative multiplier.
module tb_mul_share_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic        req0_signed = 1'b0, req1_signed = 1'b0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [63:0] resp0_result, resp1_result;
  logic [32:0] mul_src1, mul_src2;
  logic        mul_in_valid;
  logic        mul_in_ready = 1'b1;
  logic        mul_out_valid = 1'b0;
  logic [63:0] mul_result = '0;

  int tests_run = 0;
  int fails = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  // Multiplier model state
  bit          mdl_busy = 1'b0;
  int          mdl_cnt = 0;
  int          mdl_lat = 2;
  int          mdl_issues = 0;
  logic [63:0] mdl_prod = '0;
  bit          force_ov = 1'b0;

  mul_share_arb dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req0_signed(req0_signed),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .req1_signed(req1_signed),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_in_valid(mul_in_valid),
    .mul_in_ready(mul_in_ready), .mul_out_valid(mul_out_valid), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod33(input logic [32:0] a, input logic [32:0] b);
    logic [65:0] wa, wb, p;
    wa = {{33{a[32]}}, a};
    wb = {{33{b[32]}}, b};
    p  = wa * wb;
    return p[63:0];
  endfunction

  function automatic logic [63:0] exp_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic sgn);
    logic [63:0] wx, wy;
    wx = sgn ? {{32{x[31]}}, x} : {32'h0, x};
    wy = sgn ? {{32{y[31]}}, y} : {32'h0, y};
    return wx * wy;
  endfunction

  // Iterative multiplier: accepts on in_valid&in_ready, pulses out_valid mdl_lat+1 cycles later.
  always @(negedge clk) begin
    mul_out_valid = 1'b0;
    if (mdl_busy) begin
      if (mdl_cnt == 0) begin
        mul_out_valid = 1'b1;
        mul_result    = mdl_prod;
        mdl_busy      = 1'b0;
      end else begin
        mdl_cnt = mdl_cnt - 1;
      end
    end else if (mul_in_valid && mul_in_ready) begin
      mdl_busy   = 1'b1;
      mdl_cnt    = mdl_lat;
      mdl_prod   = prod33(mul_src1, mul_src2);
      mdl_issues = mdl_issues + 1;
    end
    if (force_ov) begin
      mul_out_valid = 1'b1;
      mul_result    = 64'hDEAD_BEEF_0BAD_F00D;
    end
  end

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, mul_in_valid} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 00000",
               {req0_ready, req1_ready, resp0_valid, resp1_valid, mul_in_valid});
    end
    tests_run++;
    if (resp0_result !== 64'h0 || resp1_result !== 64'h0) begin
      fails++;
      $display("FAIL reset_result got %h/%h want 0/0", resp0_result, resp1_result);
    end
    tests_run++;
    if (mul_src1 !== 33'h0 || mul_src2 !== 33'h0) begin
      fails++;
      $display("FAIL reset_src got %h/%h want 0/0", mul_src1, mul_src2);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req0_ready !== 1'b0 || resp0_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset got rdy=%b vld=%b want 0/0", req0_ready, resp0_valid);
    end
  endtask

  task automatic test_signed_req0();
    bit seen = 0, bad1 = 0;
    logic [63:0] e;
    mul_in_ready = 1'b0;
    @(posedge clk); #1;
    req0_x = 32'hFFFF_FFFF; req0_y = 32'h2; req0_signed = 1'b1; req0_valid = 1'b1;
    q0.push_back(exp_prod(req0_x, req0_y, req0_signed));
    @(negedge clk);
    tests_run++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      fails++;
      $display("FAIL signed_grant got %b want 01", {req1_ready, req0_ready});
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    // Multiplier stalls: operands must stay put while ISSUE waits.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (mul_in_valid !== 1'b1 || mul_src1 !== 33'h0_0000_0002 || mul_src2 !== 33'h1_FFFF_FFFF) begin
        fails++;
        $display("FAIL signed_issue%0d got v=%b s1=%h s2=%h want 1/000000002/1ffffffff",
                 i, mul_in_valid, mul_src1, mul_src2);
      end
    end
    @(posedge clk); #1 mul_in_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp1_valid) bad1 = 1;
      if (resp0_valid) begin seen = 1; break; end
    end
    tests_run++;
    if (!seen) begin
      fails++;
      $display("FAIL signed_resp_timeout got none want resp0_valid");
    end else begin
      e = (q0.size() > 0) ? q0.pop_front() : 64'hX;
      if (resp0_result !== e) begin
        fails++;
        $display("FAIL signed_result got %h want %h", resp0_result, e);
      end
    end
    tests_run++;
    if (bad1) begin
      fails++;
      $display("FAIL signed_resp1_quiet got resp1_valid=1 want 0");
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (resp0_valid !== 1'b0) begin
      fails++;
      $display("FAIL signed_resp_drop got %b want 0", resp0_valid);
    end
  endtask

  task automatic test_unsigned_req1();
    bit seen = 0;
    logic [63:0] e;
    @(posedge clk); #1;
    req1_x = 32'hFFFF_FFFF; req1_y = 32'hFFFF_FFFF; req1_signed = 1'b0; req1_valid = 1'b1;
    q1.push_back(exp_prod(req1_x, req1_y, req1_signed));
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mul_in_valid !== 1'b1 || mul_src1 !== 33'h0_FFFF_FFFF || mul_src2 !== 33'h0_FFFF_FFFF) begin
      fails++;
      $display("FAIL unsigned_src got v=%b s1=%h s2=%h want 1/0ffffffff/0ffffffff",
               mul_in_valid, mul_src1, mul_src2);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp1_valid) begin seen = 1; break; end
    end
    tests_run++;
    e = (q1.size() > 0) ? q1.pop_front() : 64'hX;
    if (!seen || resp1_result !== e || resp0_valid !== 1'b0) begin
      fails++;
      $display("FAIL unsigned_result got seen=%0d %h r0v=%b want %h", seen, resp1_result, resp0_valid, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alternate();
    int order[$];
    int nresp = 0;
    bit both = 0;
    logic [63:0] e;
    order = '{0, 1, 0, 1};
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    req0_x = 32'd3; req0_y = 32'd5; req0_signed = 1'b0;
    req1_x = 32'd7; req1_y = 32'd9; req1_signed = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 400 && nresp < 4; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both = 1;
      if (req0_ready || req1_ready) begin
        tests_run++;
        if (order.size() == 0 || order[0] != (req1_ready ? 1 : 0)) begin
          fails++;
          $display("FAIL alt_grant got port%0d want port%0d", req1_ready ? 1 : 0,
                   (order.size() > 0) ? order[0] : -1);
        end
        if (order.size() > 0) void'(order.pop_front());
        if (req0_ready) q0.push_back(exp_prod(req0_x, req0_y, req0_signed));
        else            q1.push_back(exp_prod(req1_x, req1_y, req1_signed));
      end
      if (resp0_valid || resp1_valid) begin
        tests_run++;
        if (resp0_valid) begin
          e = (q0.size() > 0) ? q0.pop_front() : 64'hX;
          if (resp0_result !== e) begin
            fails++;
            $display("FAIL alt_resp0 got %h want %h", resp0_result, e);
          end
        end else begin
          e = (q1.size() > 0) ? q1.pop_front() : 64'hX;
          if (resp1_result !== e) begin
            fails++;
            $display("FAIL alt_resp1 got %h want %h", resp1_result, e);
          end
        end
        nresp++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests_run++;
    if (nresp != 4 || both) begin
      fails++;
      $display("FAIL alt_summary got resp=%0d both_ready=%0d want 4/0", nresp, both);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_resp_hold();
    bit seen = 0;
    logic [63:0] e;
    resp0_ready = 1'b0;
    @(posedge clk); #1;
    req0_x = 32'h1234; req0_y = 32'h10; req0_signed = 1'b0; req0_valid = 1'b1;
    q0.push_back(exp_prod(req0_x, req0_y, req0_signed));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_x = 32'd11; req1_y = 32'd13; req1_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp0_valid) begin seen = 1; break; end
    end
    tests_run++;
    if (!seen) begin
      fails++;
      $display("FAIL hold_timeout got none want resp0_valid");
    end
    e = (q0.size() > 0) ? q0.pop_front() : 64'hX;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      tests_run++;
      if (resp0_valid !== 1'b1 || resp0_result !== e || req1_ready !== 1'b0 || resp1_valid !== 1'b0) begin
        fails++;
        $display("FAIL hold_cycle%0d got v=%b r=%h rdy1=%b want 1/%h/0", i, resp0_valid,
                 resp0_result, req1_ready, e);
      end
      @(posedge clk); #1;
      // A stray multiplier pulse during RESP must not disturb the held result.
      force_ov = (i == 4);
    end
    force_ov = 1'b0;
    resp0_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (resp0_valid !== 1'b1 || resp0_result !== e) begin
      fails++;
      $display("FAIL hold_release got v=%b r=%h want 1/%h", resp0_valid, resp0_result, e);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (resp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_idle got v=%b rdy1=%b want 0/1", resp0_valid, req1_ready);
    end
    req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_busy();
    bit seen = 0, bad = 0;
    mdl_lat = 20;
    @(posedge clk); #1;
    req1_x = 32'd5; req1_y = 32'd6; req1_signed = 1'b0; req1_valid = 1'b1;
    @(posedge clk); #1 req1_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mul_in_valid) begin seen = 1; break; end
    end
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (!seen || {req0_ready, req1_ready, resp0_valid, resp1_valid, mul_in_valid} !== 5'b0 ||
        resp1_result !== 64'h0 || mul_src1 !== 33'h0 || mul_src2 !== 33'h0) begin
      fails++;
      $display("FAIL busy_reset got issued=%0d ctrl=%b r=%h s=%h/%h want 1/00000/0/0/0", seen,
               {req0_ready, req1_ready, resp0_valid, resp1_valid, mul_in_valid}, resp1_result,
               mul_src1, mul_src2);
    end
    @(posedge clk); #1 reset = 1'b0; force_ov = 1'b1;
    @(posedge clk); #1 force_ov = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid || mul_in_valid || req0_ready || req1_ready) bad = 1;
    end
    tests_run++;
    if (bad || resp1_result !== 64'h0) begin
      fails++;
      $display("FAIL busy_reset_quiet got activity=%0d r=%h want 0/0", bad, resp1_result);
    end
    q1.delete();
    mdl_lat = 2;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc = 0, rsp = 0;
    bit chk_next = 0;
    logic [63:0] e;
    req0_x = 32'd2; req0_y = 32'd3; req0_signed = 1'b1; req0_valid = 1'b1;
    for (int c = 0; c < 100 && rsp < 2; c++) begin
      @(negedge clk);
      if (chk_next) begin
        tests_run++;
        if (req0_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_reaccept got %b want 1", req0_ready);
        end
        chk_next = 0;
      end
      if (req0_ready) begin
        acc++;
        q0.push_back(exp_prod(req0_x, req0_y, req0_signed));
      end
      if (resp0_valid) begin
        tests_run++;
        e = (q0.size() > 0) ? q0.pop_front() : 64'hX;
        if (resp0_result !== e) begin
          fails++;
          $display("FAIL b2b_result%0d got %h want %h", rsp, resp0_result, e);
        end
        rsp++;
        if (rsp == 1) chk_next = 1;
      end
      @(posedge clk); #1;
      if (acc == 1) begin req0_x = 32'hFFFF_FFFC; req0_y = 32'd5; end
      if (acc >= 2) req0_valid = 1'b0;
    end
    req0_valid = 1'b0;
    tests_run++;
    if (rsp != 2) begin
      fails++;
      $display("FAIL b2b_timeout got %0d responses want 2", rsp);
    end
  endtask

  task automatic test_zero();
    int issues0;
    bit seen = 0;
    logic [63:0] e;
    @(posedge clk); #1;
    issues0 = mdl_issues;
    req0_x = 32'h0; req0_y = 32'h1234; req0_signed = 1'b0; req0_valid = 1'b1;
    q0.push_back(exp_prod(req0_x, req0_y, req0_signed));
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
`ifdef MUL_SHARE_ZERO_SKIP_EN
    tests_run++;
    e = (q0.size() > 0) ? q0.pop_front() : 64'hX;
    if (resp0_valid !== 1'b1 || mul_in_valid !== 1'b0 || resp0_result !== e) begin
      fails++;
      $display("FAIL zero_skip got v=%b iv=%b r=%h want 1/0/%h", resp0_valid, mul_in_valid,
               resp0_result, e);
    end
    seen = 1;
    @(posedge clk); #1;
    tests_run++;
    if (mdl_issues != issues0) begin
      fails++;
      $display("FAIL zero_skip_issues got %0d want %0d", mdl_issues, issues0);
    end
`else
    tests_run++;
    if (mul_in_valid !== 1'b1) begin
      fails++;
      $display("FAIL zero_issue got %b want 1", mul_in_valid);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp0_valid) begin seen = 1; break; end
    end
    tests_run++;
    e = (q0.size() > 0) ? q0.pop_front() : 64'hX;
    if (!seen || resp0_result !== e) begin
      fails++;
      $display("FAIL zero_result got seen=%0d %h want %h", seen, resp0_result, e);
    end
    @(posedge clk); #1;
    tests_run++;
    if (mdl_issues != issues0 + 1) begin
      fails++;
      $display("FAIL zero_issues got %0d want %0d", mdl_issues, issues0 + 1);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_signed_req0();
    test_unsigned_req1();
    test_alternate();
    test_resp_hold();
    test_reset_busy();
    test_back_to_back();
    test_zero();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Two-requester scheduler that shares one iterative multiplier (basemul-style: 33-bit src1/src2, in_valid/in_ready, out_valid, 64-bit result) between two issue ports.
- Sign-extends each requester's operands to 33 bits and sequences exactly one multiply at a time.
- Routes the result back to the owning requester through a held valid/ready response.
- Sits between the two execute-stage mul issuers and the single shared multiplier instance.

Parameters:
- XLEN, 32, operand width per requester; multiplier operand width is XLEN+1.
- RES_W, 64, result width; must equal 2*XLEN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_x / req1_x  in  XLEN  multiplicand
- req0_y / req1_y  in  XLEN  multiplier
- req0_signed / req1_signed  in  1  1 = signed, 0 = unsigned
- resp0_valid / resp1_valid  out  1  result available
- resp0_ready / resp1_ready  in  1  requester takes result
- resp0_result / resp1_result  out  RES_W  product
- mul_src1  out  XLEN+1  to multiplier, {signed & y[XLEN-1], y}
- mul_src2  out  XLEN+1  to multiplier, {signed & x[XLEN-1], x}
- mul_in_valid  out  1  operands valid to multiplier
- mul_in_ready  in  1  multiplier accepts
- mul_out_valid  in  1  multiplier result valid (single-cycle pulse allowed)
- mul_result  in  RES_W  multiplier product

Behaviour:
- FSM states: IDLE, ISSUE, BUSY, RESP. Reset (async, immediate) -> IDLE.
- Reset values: all outputs 0; rr_ptr = 0 (req0 favoured); owner = 0; operand and result registers 0.
- IDLE:
  - Grant: if only one reqN_valid, grant it. If both, grant the one not equal to last_served; after reset req0 wins.
  - reqN_ready = (state==IDLE) && grant==N; combinational from valids; at most one ready high.
  - On handshake: latch x, y, signed and owner = N, then go to ISSUE.
- ISSUE:
  - mul_in_valid = 1; mul_src1/mul_src2 driven from latched registers, stable until accepted.
  - On mul_in_valid && mul_in_ready, go to BUSY.
  - mul_in_ready may already be high in the first ISSUE cycle, giving minimum one cycle in ISSUE.
- BUSY:
  - mul_in_valid = 0.
  - On mul_out_valid: capture mul_result into result register, go to RESP.
- RESP:
  - resp[owner]_valid = 1; resp[owner]_result = result register; the other resp_valid stays 0.
  - Hold until resp[owner]_ready, then last_served = owner and go to IDLE.
  - No new request is accepted in the RESP state.
- mul_out_valid outside BUSY is ignored and does not change state.
- Minimum overhead around the multiplier: 1 cycle accept (IDLE->ISSUE) plus 1 cycle RESP. Back-to-back requests from the same port are accepted in the IDLE cycle after the response handshake.
- respN_result is held stable while respN_valid is high. Outside RESP, respN_result shows the result register value (don't-care for the requester).
- Reset mid-operation returns to IDLE. The in-flight op is dropped, and any later mul_out_valid is ignored because the FSM is in IDLE.

Optional Feature:
- Macro MUL_SHARE_ZERO_SKIP_EN.
- Defined: in IDLE, if the granted x==0 or y==0, latch result = 0 and go directly to RESP. The multiplier is not used: mul_in_valid is never raised for that op.
- Undefined: every op goes through ISSUE/BUSY, including zero operands.

Decomposition:
- Package mul_share_pkg holds:
  - state enum (IDLE, ISSUE, BUSY, RESP)
  - XLEN_DEF = 32, RES_W_DEF = 64
  - helper function sext33(x, signed)
- One sub-module, rr_arb2: 2-way round-robin grant from {valid0, valid1, last_served} to one-hot grant. It is combinational; last_served is a register in the parent.

Test Plan:
- req0 signed x=0xFFFFFFFF, y=0x00000002 -> mul_src2=0x1FFFFFFFF, mul_src1=0x000000002; resp0_result=0xFFFFFFFFFFFFFFFE; resp1_valid stays 0.
- req1 unsigned x=y=0xFFFFFFFF -> mul_src1/src2=0x0FFFFFFFF; resp1_result=0xFFFFFFFE00000001.
- Both valid from reset (req0 3*5, req1 7*9), resp ready held 1 -> req0 served first (15), then req1 (63). With both kept valid, grants alternate 0,1,0,1.
- Hold resp0_ready=0 for 10 cycles in RESP -> resp0_valid and result stable for all 10 cycles; req1_ready stays 0; on release, IDLE next cycle.
- Assert reset during BUSY, then pulse mul_out_valid after deassert -> all outputs 0, state IDLE, no resp_valid generated.
- With MUL_SHARE_ZERO_SKIP_EN: req0 x=0, y=0x1234 -> resp0_valid 1 cycle after accept with result 0; mul_in_valid never asserts.
